control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge system clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have input instruction 16: current IR contents; opcode = instruction[15:13], halt field = instruction[6:0].
REQ-003 SHALL have input eq 1: ALU equality flag, 1 when the two register operands are equal.
REQ-004 SHALL have input mem_ready 1: memory completes the current request this cycle.
REQ-005 SHALL have output WE_rf 1: register file write enable.
REQ-006 SHALL have output MUX_rf 1: register file second-read select, 0 = rC, 1 = rA.
REQ-007 SHALL have output MUX_tgt 2: register file write-data select, 00 = mem_out, 01 = alu_out, 10 = pc+1.
REQ-008 SHALL have output mem_req 1 and output WE_mem 1: memory request and write strobe.
REQ-009 SHALL have output MUX_addr 1: memory address select, 0 = pc, 1 = alu_out.
REQ-010 SHALL have output WE_ir 1, output WE_pc 1 and output MUX_pc 2: PC source select, 00 = pc+1, 01 = pc+1+simm7, 10 = reg_out1.
REQ-011 SHALL have output FUNC_alu 2 (00 add, 01 nand, 10 pass-LUI, 11 compare), output MUX_alu 1 (0 = register, 1 = simm7), output halted 1 and output state 3.

Function
REQ-012 SHALL decode opcodes 000 ADD, 001 ADDI, 010 NAND, 011 LUI, 100 SW, 101 LW, 110 BEQ, 111 JALR; opcode 111 with instruction[6:0] != 0 SHALL be HALT.
REQ-013 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, driven on output state; codes 6-7 SHALL go to FETCH on the next edge.
REQ-014 FETCH: mem_req=1 and MUX_addr=0; the FSM stays in FETCH while mem_ready=0; on mem_ready=1 it asserts WE_ir=1 and goes to DECODE.
REQ-015 DECODE: no enables asserted; goes to HALT if the instruction is HALT, otherwise to EXEC.
REQ-016 EXEC: FUNC_alu and MUX_alu SHALL follow the opcode (ADDI, LW and SW use simm7).
REQ-016a From EXEC, ADD, ADDI, NAND and LUI SHALL go to WB, and LW and SW SHALL go to MEM.
REQ-017 EXEC for BEQ: SHALL assert WE_pc=1 with MUX_pc=01 if eq=1 or MUX_pc=00 if eq=0, then go to FETCH.
REQ-018 EXEC for JALR: SHALL assert WE_rf=1, MUX_tgt=10, WE_pc=1 and MUX_pc=10 in the same cycle, then go to FETCH.
REQ-019 MEM: mem_req=1 and MUX_addr=1; WE_mem SHALL be 1 only for SW; the FSM stays in MEM while mem_ready=0.
REQ-019a On mem_ready=1 in MEM: SW SHALL assert WE_pc=1 with MUX_pc=00 and go to FETCH; LW SHALL go to WB.
REQ-020 WB: SHALL assert WE_rf=1 (MUX_tgt=00 for LW, 01 otherwise) and WE_pc=1 with MUX_pc=00, then go to FETCH.
REQ-021 MUX_rf SHALL be 1 for SW and BEQ and 0 for all other opcodes, in every state after FETCH.
REQ-022 WE_pc SHALL be asserted for exactly one cycle per completed instruction; WE_rf at most one cycle; WE_ir exactly one cycle.
REQ-023 HALT: all enables SHALL be 0 and halted=1; the state is sticky until rst.
REQ-024 Outputs SHALL be combinational decodes of the registered state and instruction; only state is registered.

Reset
REQ-025 While rst=1: state SHALL load FETCH on the clock edge, and every output SHALL be forced to 0 (including mem_req, halted and MUX fields).
REQ-026 rst asserted mid-instruction (any state, including a pending memory wait) SHALL abandon the instruction, with no WE_rf, WE_pc or WE_mem pulse in that cycle.

Verification
REQ-027 Reset, then ADD (0x0000|rA1,rB2,rC3) with mem_ready=1 -> states 0,1,2,4,0; WE_rf=1 with MUX_tgt=01 in WB; one WE_pc pulse.
REQ-028 LW with mem_ready held 0 for 3 cycles in MEM -> mem_req=1, MUX_addr=1 and WE_mem=0 for 4 MEM cycles, then WB with MUX_tgt=00.
REQ-029 BEQ with eq=1 -> MUX_pc=01, WE_pc=1 in EXEC; BEQ with eq=0 -> MUX_pc=00; MUX_rf=1 in both cases and WE_rf never asserted.
REQ-030 JALR (0xE000|rA,rB, imm=0) -> a single EXEC cycle with WE_rf=1, MUX_tgt=10, WE_pc=1 and MUX_pc=10.
REQ-031 JALR with imm=1 -> HALT after DECODE; halted=1 for 20 cycles with no enables; rst -> FETCH and halted=0.
REQ-032 SW with rst pulsed during the MEM wait -> WE_mem=0 in the reset cycle and state=0 on the next cycle.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control FSM for a 16-bit, 8-opcode processor.
// Only the state is registered; every control output is decoded from the state, the instruction and the handshake inputs.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  input  logic        eq,
  input  logic        mem_ready,
  output logic        WE_rf,
  output logic        MUX_rf,
  output logic [1:0]  MUX_tgt,
  output logic        mem_req,
  output logic        WE_mem,
  output logic        MUX_addr,
  output logic        WE_ir,
  output logic        WE_pc,
  output logic [1:0]  MUX_pc,
  output logic [1:0]  FUNC_alu,
  output logic        MUX_alu,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  state_t      state_r;
  state_t      next_state_s;
  logic [2:0]  opcode_s;
  logic        is_halt_s;
  logic        uses_ra_s;
  logic        uses_imm_s;
  logic        unused_bits_s;

  function automatic logic [1:0] alu_func(input logic [2:0] op);
    logic [1:0] f;
    case (op)
      OP_NAND: f = 2'b01;
      OP_LUI:  f = 2'b10;
      OP_BEQ:  f = 2'b11;
      default: f = 2'b00;
    endcase
    return f;
  endfunction

  assign opcode_s      = instruction[15:13];
  assign is_halt_s     = (opcode_s == OP_JALR) && (instruction[6:0] != 7'd0);
  assign uses_ra_s     = (opcode_s == OP_SW) || (opcode_s == OP_BEQ);
  assign uses_imm_s    = (opcode_s == OP_ADDI) || (opcode_s == OP_LW) || (opcode_s == OP_SW);
  assign unused_bits_s = ^instruction[12:7];

  // State register; unused codes fall back to FETCH through next_state_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) next_state_s = ST_DECODE;
        else           next_state_s = ST_FETCH;
      end
      ST_DECODE: begin
        if (is_halt_s) next_state_s = ST_HALT;
        else           next_state_s = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode_s)
          OP_ADD, OP_ADDI, OP_NAND, OP_LUI: next_state_s = ST_WB;
          OP_SW, OP_LW:                     next_state_s = ST_MEM;
          default:                          next_state_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (!mem_ready)              next_state_s = ST_MEM;
        else if (opcode_s == OP_LW)  next_state_s = ST_WB;
        else                         next_state_s = ST_FETCH;
      end
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Control output decode; reset overrides everything so no write strobe escapes an abandoned instruction.
  always_comb begin
    WE_rf    = 1'b0;
    MUX_rf   = 1'b0;
    MUX_tgt  = 2'b00;
    mem_req  = 1'b0;
    WE_mem   = 1'b0;
    MUX_addr = 1'b0;
    WE_ir    = 1'b0;
    WE_pc    = 1'b0;
    MUX_pc   = 2'b00;
    FUNC_alu = 2'b00;
    MUX_alu  = 1'b0;
    halted   = 1'b0;
    state    = 3'd0;
    if (rst) begin
      state = 3'd0;
    end else begin
      state = state_r;
      case (state_r)
        ST_FETCH: begin
          mem_req = 1'b1;
          WE_ir   = mem_ready;
        end
        ST_DECODE: begin
          MUX_rf = uses_ra_s;
        end
        ST_EXEC: begin
          MUX_rf   = uses_ra_s;
          FUNC_alu = alu_func(opcode_s);
          MUX_alu  = uses_imm_s;
          case (opcode_s)
            OP_BEQ: begin
              WE_pc  = 1'b1;
              MUX_pc = eq ? 2'b01 : 2'b00;
            end
            OP_JALR: begin
              WE_rf   = 1'b1;
              MUX_tgt = 2'b10;
              WE_pc   = 1'b1;
              MUX_pc  = 2'b10;
            end
            default: begin
              WE_pc = 1'b0;
            end
          endcase
        end
        ST_MEM: begin
          MUX_rf   = uses_ra_s;
          mem_req  = 1'b1;
          MUX_addr = 1'b1;
          WE_mem   = (opcode_s == OP_SW);
          WE_pc    = mem_ready && (opcode_s == OP_SW);
        end
        ST_WB: begin
          MUX_rf  = uses_ra_s;
          WE_rf   = 1'b1;
          MUX_tgt = (opcode_s == OP_LW) ? 2'b00 : 2'b01;
          WE_pc   = 1'b1;
        end
        ST_HALT: begin
          MUX_rf = uses_ra_s;
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule
